data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; must be a power of two.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 MEM_addr  input  32  byte address from the CPU.
REQ-006 MEM_WR_out  input  32  store data from the CPU; the low byte or halfword is used for narrow stores.
REQ-007 MEM_type  input  3  transfer type: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; all other codes are illegal.
REQ-008 MEM_rd_en  input  1  load request; held by the CPU until MEM_ready.
REQ-009 MEM_wr_en  input  1  store request; held by the CPU until MEM_ready.
REQ-010 MEM_data  output  32  registered load data, extended per MEM_type.
REQ-011 MEM_ready  output  1  one-cycle pulse marking completion of the accepted request.
REQ-012 MEM_fault  output  1  valid with MEM_ready; high means the request was rejected.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP; the state and all outputs SHALL be registered.
REQ-014 In IDLE, a rising edge with MEM_rd_en or MEM_wr_en high SHALL accept the request.
- Acceptance latches addr, type, wdata and the op, loads the counter, and moves to WAIT.
REQ-015 Inputs SHALL be ignored outside IDLE; a held request is not re-accepted while WAIT or RESP is in progress.
REQ-016 MEM_ready SHALL rise at the LATENCY-th rising edge after the accepting edge and stay high for exactly one cycle (RESP).
- RESP returns to IDLE on the next edge.
- A request still held in that IDLE cycle is accepted as a new transaction.
REQ-017 Back-to-back throughput SHALL be one transaction per LATENCY+1 cycles.
REQ-018 A store SHALL update the array on the same edge that raises MEM_ready, writing only the addressed lanes:
- byte: lane addr[1:0];
- half: lanes {addr[1],0} and {addr[1],1};
- word: all four lanes.
- Storage is little-endian.
REQ-019 A load SHALL register MEM_data on the edge that raises MEM_ready.
- The selected byte or half SHALL be sign-extended for codes 000 and 001, and zero-extended for 100 and 101.
- Word loads return the full word.
REQ-020 A load issued after a completed store to the same word SHALL return the stored data (no stale read).
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]. An address with any higher bit set is out of range and SHALL fault.
REQ-022 MEM_fault=1 with MEM_ready SHALL be returned, with no array write and MEM_data=0, for any of:
- an illegal MEM_type;
- a store with type 100 or 101;
- a half access with addr[0]=1;
- a word access with addr[1:0]≠00;
- an out-of-range address;
- MEM_rd_en and MEM_wr_en both high at acceptance.
REQ-023 A faulting request SHALL keep the same LATENCY timing as a good one.
REQ-024 MEM_data SHALL hold its last value between responses; store responses SHALL drive MEM_data=0.

Reset
REQ-025 While Reset is high the FSM SHALL be in IDLE, and MEM_ready=0, MEM_fault=0, MEM_data=0, counter=0.
REQ-026 Reset asserted during WAIT or RESP SHALL abort the transaction: no array write and no MEM_ready pulse.
REQ-027 Array contents SHALL NOT be cleared by Reset.
REQ-028 The first request SHALL be accepted on the first rising edge after Reset deasserts.

Verification
REQ-029 LATENCY=2: store word 0xDEADBEEF at 0x10, then load word 0x10 -> each MEM_ready arrives 2 edges after acceptance; load returns 0xDEADBEEF with MEM_fault=0.
REQ-030 Store byte 0x80 at 0x13, then load type 000 at 0x13 -> 0xFFFFFF80; load type 100 -> 0x00000080; load word at 0x10 -> 0x80ADBEEF.
REQ-031 Store half 0x1234 at 0x22 over word 0, then load word at 0x20 -> 0x12340000.
REQ-031 (cont.) Load type 001 at 0x21 -> MEM_fault=1, MEM_data=0.
REQ-032 Store word at addr 4*DEPTH_WORDS -> MEM_fault=1 and the array is unchanged.
REQ-032 (cont.) MEM_rd_en=MEM_wr_en=1 -> MEM_fault=1; MEM_type=011 -> MEM_fault=1.
REQ-033 Assert Reset one cycle after a store is accepted -> no MEM_ready pulse, all outputs 0; a subsequent load returns the old word.
REQ-034 Hold MEM_rd_en high continuously with LATENCY=1 -> a MEM_ready pulse every 2 cycles; the pulse is never wider than 1 cycle.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// CPU data-memory request/response bundle shared by the responder and its requester.
interface data_mem_responder_if;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_WR_out;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en;
  logic        MEM_wr_en;
  logic [31:0] MEM_data;
  logic        MEM_ready;
  logic        MEM_fault;

  modport master (
    output MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
    input  MEM_data, MEM_ready, MEM_fault
  );

  modport slave (
    input  MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
    output MEM_data, MEM_ready, MEM_fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency byte-addressable data memory answering one CPU load/store at a time,
// with lane-masked stores, sign/zero-extended loads and fault responses for bad requests.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  data_mem_responder_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            ready_q;
  logic            fault_q;
  logic [31:0]     data_q;

  logic            wr_p0;
  logic            fault_p0;
  logic [AW+1:0]   addr_p0;
  logic [2:0]      type_p0;
  logic [31:0]     wdata_p0;

  logic            accept;
  logic            fire;
  logic            acc_fault;
  logic            legal_type;
  logic            misalign;
  logic            out_of_range;
  logic [AW-1:0]   idx_p0;
  logic [3:0]      be;
  logic [31:0]     wlane;
  logic            we;
  logic [31:0]     rword;
  logic [31:0]     load_val;

  logic [31:0]     mem [DEPTH_WORDS];

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  typ);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] sx;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (typ)
      3'b000:  sx = 32'(signed'(b));
      3'b001:  sx = 32'(signed'(h));
      3'b100:  sx = signed'({24'h0, b});
      3'b101:  sx = signed'({16'h0, h});
      default: sx = signed'(word);
    endcase
    return unsigned'(sx);
  endfunction

  assign accept = (state == IDLE) && (bus.MEM_rd_en || bus.MEM_wr_en);
  // The response edge is the one leaving RESP, or leaving WAIT directly when LATENCY is 1.
  assign fire   = (state == RESP) || ((state == WAIT) && (cnt == 4'd0));

  always_comb begin
    legal_type = 1'b0;
    case (bus.MEM_type)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_type = 1'b1;
      default:                                legal_type = 1'b0;
    endcase
    misalign     = ((bus.MEM_type[1:0] == 2'b01) && bus.MEM_addr[0]) ||
                   ((bus.MEM_type[1:0] == 2'b10) && (bus.MEM_addr[1:0] != 2'b00));
    out_of_range = |bus.MEM_addr[31:AW+2];
    acc_fault    = !legal_type || (bus.MEM_wr_en && bus.MEM_type[2]) || misalign ||
                   out_of_range || (bus.MEM_rd_en && bus.MEM_wr_en);
  end

  // Request capture (stage p0): fields held for the whole transaction.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_p0  <= bus.MEM_addr[AW+1:0];
      type_p0  <= bus.MEM_type;
      wdata_p0 <= bus.MEM_WR_out;
    end
  end

  assign idx_p0 = addr_p0[AW+1:2];

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_p0;
    case (type_p0[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_p0[1:0];
        wlane = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        be    = addr_p0[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_p0[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_p0;
      end
    endcase
  end

  assign we       = fire && wr_p0 && !fault_p0;
  assign rword    = mem[idx_p0];
  assign load_val = load_extend(rword, addr_p0[1:0], type_p0);

  // Storage is never reset; an aborted transaction leaves state IDLE so we stays low.
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_p0][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Control and response registers (stage p1).
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      data_q   <= 32'h0;
      wr_p0    <= 1'b0;
      fault_p0 <= 1'b0;
    end else begin
      ready_q <= fire;
      fault_q <= fire && fault_p0;
      if (fire) data_q <= (fault_p0 || wr_p0) ? 32'h0 : load_val;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= WAIT;
            cnt      <= CNT_INIT;
            wr_p0    <= bus.MEM_wr_en;
            fault_p0 <= acc_fault;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MEM_ready = ready_q;
  assign bus.MEM_fault = fault_q;
  assign bus.MEM_data  = data_q;

endmodule
